// File: rtl/see_inject_ctrl.sv
// SEU injection sequencer: walks every input vector and bit, drives golden/faulty target copies, compares outputs.
// Optional multi-bit-upset (adjacent pair, wrapping) mask selected by defining SEE_MBU_EN.
module see_inject_ctrl #(
  parameter int IN_W   = 9,
  parameter int OUT_W  = 5,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] golden_i,
  input  logic [OUT_W-1:0] faulty_i,
  output logic [IN_W-1:0]  vec_gold_o,
  output logic [IN_W-1:0]  vec_fault_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] inj_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [OUT_W-1:0] err_mask,
  output logic [1:0]       dbg_state
);

  localparam int BIT_W  = $clog2(IN_W);
  localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(IN_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [IN_W-1:0]   vec_q;
  logic [BIT_W-1:0]  bit_q;
  logic [WAIT_W-1:0] wait_q;

  logic              last_bit;
  logic              last_pair;
  logic [BIT_W-1:0]  bit_nx;
  logic [IN_W-1:0]   vec_nx;
  logic [OUT_W-1:0]  diff;

  function automatic logic [IN_W-1:0] flip(input logic [BIT_W-1:0] b);
    logic [IN_W-1:0] m;
`ifdef SEE_MBU_EN
    logic [BIT_W-1:0] nb;
`endif
    m = IN_W'(1) << b;
`ifdef SEE_MBU_EN
    nb = (b == LAST_BIT) ? '0 : b + 1'b1;
    m  = m | (IN_W'(1) << nb);
`endif
    return m;
  endfunction

  assign diff      = golden_i ^ faulty_i;
  assign last_bit  = (bit_q == LAST_BIT);
  assign last_pair = last_bit && (&vec_q);
  assign bit_nx    = last_bit ? '0 : bit_q + 1'b1;
  assign vec_nx    = last_bit ? vec_q + 1'b1 : vec_q;
  assign dbg_state = state;

  // start and abort are single-cycle level-sampled controls (no handshake):
  // start is honoured only in S_IDLE, abort in any other state and wins over sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      vec_q       <= '0;
      bit_q       <= '0;
      wait_q      <= '0;
      vec_gold_o  <= '0;
      vec_fault_o <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      inj_cnt     <= '0;
      err_cnt     <= '0;
      err_mask    <= '0;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            inj_cnt     <= '0;
            err_cnt     <= '0;
            err_mask    <= '0;
            done        <= 1'b0;
            vec_q       <= '0;
            bit_q       <= '0;
            vec_gold_o  <= '0;
            vec_fault_o <= flip('0);
            wait_q      <= WAIT_LOAD;
            busy        <= 1'b1;
            state       <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (wait_q == '0) state <= S_SAMPLE;
          else              wait_q <= wait_q - 1'b1;
        end
        S_SAMPLE: begin
          if (inj_cnt != '1) inj_cnt <= inj_cnt + 1'b1;
          if (diff != '0) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            err_mask <= err_mask | diff;
          end
          if (last_pair) begin
            // Vectors hold their final pair; the sweep is complete.
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            vec_q       <= vec_nx;
            bit_q       <= bit_nx;
            vec_gold_o  <= vec_nx;
            vec_fault_o <= vec_nx ^ flip(bit_nx);
            wait_q      <= WAIT_LOAD;
            state       <= S_SETTLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_see_inject_ctrl.sv
// Bench for see_inject_ctrl: one default instance (SETTLE=2) and one SETTLE=1, CNT_W=8 instance.
module tb_see_inject_ctrl;

  localparam int IN_W     = 9;
  localparam int OUT_W    = 5;
  localparam int A_SETTLE = 2;
  localparam int A_CNT    = 16;
  localparam int B_SETTLE = 1;
  localparam int B_CNT    = 8;
  localparam int PAIRS    = IN_W * (1 << IN_W);
  localparam int RW       = 2 * A_CNT + OUT_W;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic             a_start, a_abort;
  logic [OUT_W-1:0] a_golden, a_faulty;
  logic [IN_W-1:0]  a_vg, a_vf;
  logic             a_busy, a_done;
  logic [A_CNT-1:0] a_inj, a_err;
  logic [OUT_W-1:0] a_mask;
  logic [1:0]       a_state;

  logic             b_start, b_abort;
  logic [OUT_W-1:0] b_golden, b_faulty;
  logic [IN_W-1:0]  b_vg, b_vf;
  logic             b_busy, b_done;
  logic [B_CNT-1:0] b_inj, b_err;
  logic [OUT_W-1:0] b_mask;
  logic [1:0]       b_state;

  int a_mode;
  int checks = 0;
  int errors = 0;

  logic [RW-1:0]     exp_q[$];
  logic [2*IN_W-1:0] pair_q[$];

  see_inject_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(A_SETTLE), .CNT_W(A_CNT)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .golden_i(a_golden), .faulty_i(a_faulty),
    .vec_gold_o(a_vg), .vec_fault_o(a_vf), .busy(a_busy), .done(a_done),
    .inj_cnt(a_inj), .err_cnt(a_err), .err_mask(a_mask), .dbg_state(a_state)
  );

  see_inject_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(B_SETTLE), .CNT_W(B_CNT)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .golden_i(b_golden), .faulty_i(b_faulty),
    .vec_gold_o(b_vg), .vec_fault_o(b_vf), .busy(b_busy), .done(b_done),
    .inj_cnt(b_inj), .err_cnt(b_err), .err_mask(b_mask), .dbg_state(b_state)
  );

  function automatic logic [OUT_W-1:0] tf(input logic [IN_W-1:0] v);
    return v[4:0] & v[8:4];
  endfunction

  function automatic logic [IN_W-1:0] fmask(input int b);
    logic [IN_W-1:0] m;
    m = '0;
    m[b] = 1'b1;
`ifdef SEE_MBU_EN
    m[(b + 1) % IN_W] = 1'b1;
`endif
    return m;
  endfunction

  // mode 0: clean, 1: stuck bit-2 difference, 2: real target function on both copies
  always_comb begin
    a_golden = '0;
    a_faulty = '0;
    case (a_mode)
      1: begin a_golden = tf(a_vg); a_faulty = a_golden ^ 5'b00100; end
      2: begin a_golden = tf(a_vg); a_faulty = tf(a_vf); end
      default: ;
    endcase
  end

  always_comb begin
    b_golden = b_vg[OUT_W-1:0];
    b_faulty = b_golden ^ 5'b00001;
  end

  function automatic logic [RW-1:0] model_a(input int mode);
    int inj, err;
    logic [OUT_W-1:0] msk, g, f;
    logic [IN_W-1:0] vv;
    inj = 0; err = 0; msk = '0;
    for (int v = 0; v < (1 << IN_W); v++) begin
      for (int b = 0; b < IN_W; b++) begin
        vv = IN_W'(v);
        g = '0; f = '0;
        if (mode == 1) begin g = tf(vv); f = g ^ 5'b00100; end
        if (mode == 2) begin g = tf(vv); f = tf(vv ^ fmask(b)); end
        inj++;
        if (g != f) begin err++; msk = msk | (g ^ f); end
      end
    end
    if (inj > 65535) inj = 65535;
    if (err > 65535) err = 65535;
    return {inj[15:0], err[15:0], msk};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor for dut_b: every new vector pair is popped from the expected queue and must arrive SETTLE+1 cycles apart.
  logic [2*IN_W-1:0] b_last = '0;
  int b_since = 0;
  bit b_have_prev = 1'b0;
  always @(negedge clk) begin
    logic [2*IN_W-1:0] p;
    if (!b_busy) begin
      b_have_prev = 1'b0;
      b_since = 0;
    end else begin
      b_since++;
      if ({b_vg, b_vf} != b_last) begin
        if (pair_q.size() == 0) begin
          check("b_unexpected_pair", 64'(1), 64'(0));
        end else begin
          p = pair_q.pop_front();
          check("b_vec_gold", 64'(b_vg), 64'(p[2*IN_W-1:IN_W]));
          check("b_vec_fault", 64'(b_vf), 64'(p[IN_W-1:0]));
        end
        if (b_have_prev) check("b_period", 64'(b_since), 64'(B_SETTLE + 1));
        b_have_prev = 1'b1;
        b_since = 0;
      end
    end
    b_last = {b_vg, b_vf};
  end

  task automatic pulse_a_start();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("a_start_busy", 64'(a_busy), 64'(1));
    check("a_start_done", 64'(a_done), 64'(0));
    check("a_start_inj", 64'(a_inj), 64'(0));
    check("a_start_err", 64'(a_err), 64'(0));
    check("a_start_mask", 64'(a_mask), 64'(0));
    check("a_start_vg", 64'(a_vg), 64'(0));
    check("a_start_vf", 64'(a_vf), 64'(fmask(0)));
  endtask

  task automatic finish_a(input string tag);
    int busy_cyc;
    bit hit;
    logic [RW-1:0] e;
    busy_cyc = 0;
    hit = 1'b0;
    for (int i = 0; i < PAIRS * 4 + 100; i++) begin
      if (a_done) begin hit = 1'b1; break; end
      if (a_busy) busy_cyc++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 64'(hit), 64'(1));
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(PAIRS * (A_SETTLE + 1)));
    check({tag, "_busy_low"}, 64'(a_busy), 64'(0));
    if (exp_q.size() == 0) begin
      check({tag, "_exp_q_empty"}, 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_inj"}, 64'(a_inj), 64'(e[RW-1 -: A_CNT]));
      check({tag, "_err"}, 64'(a_err), 64'(e[OUT_W +: A_CNT]));
      check({tag, "_mask"}, 64'(a_mask), 64'(e[OUT_W-1:0]));
    end
    @(negedge clk);
    check({tag, "_idle"}, 64'(a_state), 64'(0));
    check({tag, "_done_held"}, 64'(a_done), 64'(1));
  endtask

  initial begin
    logic [RW-1:0] e;
    int idx, lim;
    bit hit;
    rst = 1'b1; a_start = 1'b1; b_start = 1'b1; a_abort = 1'b0; b_abort = 1'b0; a_mode = 0;
    repeat (2) @(negedge clk);
    check("rst_a_vg", 64'(a_vg), 64'(0));
    check("rst_a_vf", 64'(a_vf), 64'(0));
    check("rst_a_busy", 64'(a_busy), 64'(0));
    check("rst_a_done", 64'(a_done), 64'(0));
    check("rst_a_cnts", 64'({a_inj, a_err, a_mask}), 64'(0));
    check("rst_a_state", 64'(a_state), 64'(0));
    check("rst_b_busy", 64'({b_busy, b_done, b_state}), 64'(0));
    rst = 1'b0; a_start = 1'b0; b_start = 1'b0;
    @(negedge clk);
    check("idle_a_busy", 64'(a_busy), 64'(0));

    // clean loopback
    a_mode = 0;
    exp_q.push_back(model_a(0));
    pulse_a_start();
    finish_a("clean");

    // stuck difference on output bit 2
    a_mode = 1;
    exp_q.push_back(model_a(1));
    pulse_a_start();
    finish_a("stuck");

    // abort sampled 100 edges after the start edge
    a_mode = 1;
    pulse_a_start();
    repeat (99) @(negedge clk);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    idx = 100 / (A_SETTLE + 1);
    check("abort_busy", 64'(a_busy), 64'(0));
    check("abort_done", 64'(a_done), 64'(0));
    check("abort_state", 64'(a_state), 64'(0));
    check("abort_inj", 64'(a_inj), 64'(idx));
    check("abort_err", 64'(a_err), 64'(idx));
    check("abort_mask", 64'(a_mask), 64'(5'b00100));
    check("abort_vg", 64'(a_vg), 64'(idx / IN_W));
    check("abort_vf", 64'(a_vf), 64'(IN_W'(idx / IN_W) ^ fmask(idx % IN_W)));
    repeat (5) @(negedge clk);
    check("abort_inj_held", 64'(a_inj), 64'(idx));
    check("abort_vg_held", 64'(a_vg), 64'(idx / IN_W));

    // restart after abort with a real target function
    a_mode = 2;
    exp_q.push_back(model_a(2));
    pulse_a_start();
    finish_a("func");

    // dut_b: sequencing, saturation, ignored mid-campaign start
    for (int v = 0; v < (1 << IN_W); v++)
      for (int b = 0; b < IN_W; b++)
        pair_q.push_back({IN_W'(v), IN_W'(v) ^ fmask(b)});
    lim = (PAIRS > 255) ? 255 : PAIRS;
    exp_q.push_back({16'(lim), 16'(lim), 5'b00001});
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < PAIRS * 3 + 100; i++) begin
      if (b_done) begin hit = 1'b1; break; end
      b_start = (i == 1000) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    b_start = 1'b0;
    check("sat_done_seen", 64'(hit), 64'(1));
    check("sat_busy_low", 64'(b_busy), 64'(0));
    check("sat_pairs_left", 64'(pair_q.size()), 64'(0));
    if (exp_q.size() == 0) begin
      check("sat_exp_q_empty", 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      check("sat_inj", 64'(b_inj), 64'(e[RW-1 -: A_CNT]));
      check("sat_err", 64'(b_err), 64'(e[OUT_W +: A_CNT]));
      check("sat_mask", 64'(b_mask), 64'(e[OUT_W-1:0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/see_inject_ctrl.md
# see_inject_ctrl

Sequencer for input-side single-event-upset (SEU) sensitivity campaigns on a combinational target netlist. It walks every input vector and every input bit. For each pair it drives a golden copy of the target with the clean vector and a faulty copy with that bit flipped. After a settle time it compares the two output buses and accumulates error statistics. It sits above two externally instantiated copies of the target, which it drives through registered vector buses.

## Interface
- IN_W, 9, target input width (≥2)
- OUT_W, 5, target output width (≥1)
- SETTLE, 2, cycles between applying a vector pair and sampling outputs (≥1)
- CNT_W, 16, width of saturating counters
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  campaign start pulse, honoured only in IDLE
- abort  in  1  stop campaign; honoured in any non-IDLE state
- golden_i  in  OUT_W  outputs of golden target copy
- faulty_i  in  OUT_W  outputs of faulty target copy
- vec_gold_o  out  IN_W  registered stimulus to golden copy
- vec_fault_o  out  IN_W  registered stimulus to faulty copy (vec_gold_o XOR flip mask)
- busy  out  1  campaign in progress
- done  out  1  level; set on campaign completion, cleared by next accepted start or rst
- inj_cnt  out  CNT_W  injections sampled, saturating
- err_cnt  out  CNT_W  injections with any output mismatch, saturating
- err_mask  out  OUT_W  sticky OR of (golden_i ^ faulty_i) over all samples

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset: all outputs 0, state IDLE, internal vec/bit/wait counters 0.
- IDLE, start=1:
  - clear inj_cnt, err_cnt, err_mask and done
  - set vec=0, bit=0
  - drive vec_gold_o=0 and vec_fault_o=flip(0)
  - load wait=SETTLE-1; go to SETTLE; busy=1
- SETTLE: decrement wait; go to SAMPLE when wait==0.
- SAMPLE (one cycle):
  - inj_cnt+1
  - if golden_i≠faulty_i: err_cnt+1 and err_mask |= golden_i^faulty_i
  - Then advance the pair: if bit==IN_W-1 set bit=0 and vec+1, otherwise bit+1.
  - Drive the new vectors and reload wait.
  - Go to SETTLE, or to DONE if the sampled pair was vec=2^IN_W-1, bit=IN_W-1.
- DONE: done=1 and busy=0 at the entry edge; next cycle IDLE. done stays high.
- Flip mask: one-hot 1<<bit (see Configuration).
- Counters saturate at 2^CNT_W-1 and do not wrap. Saturation of inj_cnt does not end the campaign.
- abort (non-IDLE):
  - next edge: state IDLE, busy=0, done=0
  - counters and err_mask hold their values
  - vec_*_o hold their values
- abort has priority over SAMPLE updates in the same cycle.
- start while busy is ignored. start and abort together in IDLE: abort is a no-op and start is accepted.
- rst mid-campaign: full reset at that edge, same as power-on.

## Timing
- Edge E0 accepts start. vec_*_o are valid after E0. The first sample is taken at edge E0+SETTLE+1.
- Each injection period is SETTLE+1 cycles. The sample edge also launches the next pair.
- Total injections = IN_W·2^IN_W. The defaults give 4608, with DONE entered at edge E0+4608·3 = E0+13824.
- Combinational path from vec_*_o through the target to golden_i/faulty_i must settle within SETTLE cycles. golden_i/faulty_i are sampled without synchronisers.
- busy rises at E0 and falls at the DONE or abort edge.

## Configuration
- SEE_MBU_EN defined: multi-bit-upset mode.
  - Flip mask is (1<<bit) | (1<<((bit+1) mod IN_W)), i.e. adjacent pair with wrap.
  - Injection count and sequencing are unchanged.
- SEE_MBU_EN undefined: single-bit one-hot mask only, and no MBU logic is synthesised.

## Test plan
- Reset check: assert rst for 2 cycles with start=1 → all outputs 0, state IDLE, busy=0.
- Clean loopback, faulty_i=golden_i=5'h00, start pulse → busy=1 for 13824 cycles, then done=1, inj_cnt=4608, err_cnt=0, err_mask=0.
- Stuck difference, faulty_i=golden_i^5'b00100 → err_cnt=4608, err_mask=5'b00100.
- Vector sequencing, SETTLE=1, default widths, single-bit mode → vec_fault_o sequence is 0x001, 0x002, …, 0x100, then 0x000 with vec_gold_o=0x001.
  - vec_*_o change every 2 cycles.
  - With SEE_MBU_EN: first fault mask 0x003, last 0x101.
- Abort and restart:
  - abort 100 cycles after start (SETTLE=2) → busy=0 and done=0 next edge, inj_cnt=33 held.
  - A subsequent start clears the counters and restarts from vec=0.
- Saturation and ignored start: CNT_W=8, always-mismatch → err_cnt=inj_cnt=255 at done. A start pulse mid-campaign changes nothing.
